// File: rtl/uart_cmd_parser.sv
// Three-byte UART command framer (A5, CMD, ~CMD) that turns valid commands into one-hot action pulses.
// Optional saturating frame-error counter enabled by defining UART_CMD_PARSER_ERRCNT_EN.
module uart_cmd_parser #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000,
    parameter logic [3:0]  COOLDOWN_SECS  = 4'd3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       second,
    input  logic       is_sleeping,
    output logic [5:0] action,
    output logic [7:0] ack_data,
    output logic       ack_valid,
    input  logic       ack_ready,
    output logic [3:0] err_cnt
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SYNC_OK = 2'd1;
    localparam logic [1:0] ST_CMD_OK  = 2'd2;
    localparam logic [1:0] ST_RESP    = 2'd3;

    localparam logic [7:0] SYNC_BYTE    = 8'hA5;
    localparam logic [7:0] ACK_BAD_CHK  = 8'hE1;
    localparam logic [7:0] ACK_BAD_CMD  = 8'hE2;
    localparam logic [7:0] ACK_COOLDOWN = 8'hE3;
    localparam logic [7:0] ACK_ASLEEP   = 8'hE4;

    logic [1:0]  state_q, state_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [23:0] tmo_cnt_q, tmo_cnt_d;
    logic [3:0]  cooldown_q, cooldown_d;
    logic [5:0]  action_q, action_d;
    logic [7:0]  ack_data_q, ack_data_d;
    logic        ack_valid_q, ack_valid_d;

    logic        chk_ok;
    logic        cmd_known;
    logic        accept;
    logic        tmo_hit;
    logic [7:0]  resp_code;

    // Frame evaluation for the CHK byte, in priority order.
    always_comb begin
        chk_ok    = (rx_data == ~cmd_q);
        cmd_known = (cmd_q >= 8'h01) && (cmd_q <= 8'h06);
        accept    = 1'b0;
        if (!chk_ok) begin
            resp_code = ACK_BAD_CHK;
        end else if (!cmd_known) begin
            resp_code = ACK_BAD_CMD;
        end else if (is_sleeping && (cmd_q != 8'h05)) begin
            resp_code = ACK_ASLEEP;
        end else if (cooldown_q != 4'd0) begin
            resp_code = ACK_COOLDOWN;
        end else begin
            resp_code = 8'h80 | cmd_q;
            accept    = 1'b1;
        end
        tmo_hit = ((state_q == ST_SYNC_OK) || (state_q == ST_CMD_OK)) && !rx_valid
                  && (tmo_cnt_q == TIMEOUT_CYCLES - 24'd1);
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        tmo_cnt_d   = '0;
        action_d    = '0;
        ack_data_d  = ack_data_q;
        ack_valid_d = ack_valid_q;
        cooldown_d  = cooldown_q;
        if (second && (cooldown_q != 4'd0)) begin
            cooldown_d = cooldown_q - 4'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    state_d = ST_SYNC_OK;
                end
            end
            ST_SYNC_OK: begin
                if (rx_valid) begin
                    cmd_d   = rx_data;
                    state_d = ST_CMD_OK;
                end else if (tmo_hit) begin
                    state_d = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 24'd1;
                end
            end
            ST_CMD_OK: begin
                if (rx_valid) begin
                    state_d     = ST_RESP;
                    ack_valid_d = 1'b1;
                    ack_data_d  = resp_code;
                    if (accept) begin
                        action_d   = 6'b000001 << (cmd_q[2:0] - 3'd1);
                        cooldown_d = COOLDOWN_SECS;
                    end
                end else if (tmo_hit) begin
                    state_d = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 24'd1;
                end
            end
            ST_RESP: begin
                if (ack_ready) begin
                    ack_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments and an asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cmd_q       <= 8'h00;
            tmo_cnt_q   <= '0;
            cooldown_q  <= 4'd0;
            action_q    <= '0;
            ack_data_q  <= 8'h00;
            ack_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            tmo_cnt_q   <= tmo_cnt_d;
            cooldown_q  <= cooldown_d;
            action_q    <= action_d;
            ack_data_q  <= ack_data_d;
            ack_valid_q <= ack_valid_d;
        end
    end

    assign action    = action_q;
    assign ack_data  = ack_data_q;
    assign ack_valid = ack_valid_q;

`ifdef UART_CMD_PARSER_ERRCNT_EN
    logic       err_inc;
    logic [3:0] err_cnt_q, err_cnt_d;

    // Bad checksum/command, inter-byte timeout and bytes arriving while a response is pending.
    always_comb begin
        err_inc = tmo_hit
                  || ((state_q == ST_RESP) && rx_valid)
                  || ((state_q == ST_CMD_OK) && rx_valid && (!chk_ok || !cmd_known));
        err_cnt_d = err_cnt_q;
        if (err_inc && (err_cnt_q != 4'hF)) begin
            err_cnt_d = err_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 4'h0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 4'h0;
`endif

endmodule
